uart_tx_arbiter: RTL and testbench

//   Round-robin scheduler sharing one UART byte transmitter between NUM_REQ requesters.

---
 rtl/uart_tx_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART byte transmitter between NUM_REQ requesters.
// A multi-byte message (terminated by req_last) keeps the grant so strings never interleave.
module uart_tx_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 8,
    parameter int START_TO = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_send,
    output logic [DATA_W-1:0]          tx_data,
    input  logic                       tx_busy,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       locked,
    output logic                       err_timeout
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (START_TO > 1) ? $clog2(START_TO + 1) : 1;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_ISSUE      = 2'd1;
    localparam logic [1:0] ST_WAIT_START = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE  = 2'd3;

    // Returns {found, index} of the first set candidate at or after ptr, wrapping.
    function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] cand,
                                            input logic [IW-1:0]      ptr);
        logic [IW:0] res;
        int unsigned idx;
        res = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            idx = 32'(ptr) + 32'(j);
            if (idx >= 32'(NUM_REQ)) begin
                idx = idx - 32'(NUM_REQ);
            end else begin
                idx = idx;
            end
            if (!res[IW] && cand[idx[IW-1:0]]) begin
                res = {1'b1, idx[IW-1:0]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] k);
        logic [IW-1:0] r;
        if (32'(k) >= 32'(NUM_REQ - 1)) begin
            r = '0;
        end else begin
            r = k + IW'(1);
        end
        return r;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] k);
        logic [NUM_REQ-1:0] r;
        r    = '0;
        r[k] = 1'b1;
        return r;
    endfunction

    logic [1:0]          state_r;
    logic [IW-1:0]       ptr_r;
    logic [IW-1:0]       owner_r;
    logic                last_q_r;
    logic [CW-1:0]       cnt_r;
    logic [NUM_REQ-1:0]  req_ready_r;
    logic                tx_send_r;
    logic [DATA_W-1:0]   tx_data_r;
    logic [NUM_REQ-1:0]  grant_r;
    logic                locked_r;
    logic                err_timeout_r;

    logic [NUM_REQ-1:0]  cand_s;
    logic [IW:0]         pick_s;
    logic                pick_found_s;
    logic [IW-1:0]       pick_idx_s;
    logic [DATA_W-1:0]   pick_data_s;
    logic                pick_last_s;

    // Candidate set and round-robin selection; while locked only the owner may be picked.
    always_comb begin
        if (locked_r) begin
            cand_s = req_valid & grant_r;
        end else begin
            cand_s = req_valid;
        end
        pick_s       = rr_pick(cand_s, ptr_r);
        pick_found_s = pick_s[IW];
        pick_idx_s   = pick_s[IW-1:0];
    end

    // Byte and last flag of the selected requester.
    always_comb begin
        pick_data_s = '0;
        pick_last_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx_s == IW'(i)) begin
                pick_data_s = req_data[i*DATA_W +: DATA_W];
                pick_last_s = req_last[i];
            end else begin
                pick_data_s = pick_data_s;
                pick_last_s = pick_last_s;
            end
        end
    end

    // Scheduler state machine with registered outputs; pulses default low each cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            ptr_r         <= '0;
            owner_r       <= '0;
            last_q_r      <= 1'b0;
            cnt_r         <= '0;
            req_ready_r   <= '0;
            tx_send_r     <= 1'b0;
            tx_data_r     <= '0;
            grant_r       <= '0;
            locked_r      <= 1'b0;
            err_timeout_r <= 1'b0;
        end else begin
            req_ready_r   <= '0;
            tx_send_r     <= 1'b0;
            err_timeout_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (!tx_busy && pick_found_s) begin
                        owner_r     <= pick_idx_s;
                        grant_r     <= onehot(pick_idx_s);
                        tx_data_r   <= pick_data_s;
                        last_q_r    <= pick_last_s;
                        req_ready_r <= onehot(pick_idx_s);
                        tx_send_r   <= 1'b1;
                        state_r     <= ST_ISSUE;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    cnt_r   <= '0;
                    state_r <= ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    if (tx_busy) begin
                        state_r <= ST_WAIT_DONE;
                    end else if (cnt_r == CW'(START_TO - 1)) begin
                        // Transmitter never started: abandon the message and move on.
                        err_timeout_r <= 1'b1;
                        locked_r      <= 1'b0;
                        grant_r       <= '0;
                        ptr_r         <= next_ptr(owner_r);
                        state_r       <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        state_r <= ST_IDLE;
                        if (last_q_r) begin
                            locked_r <= 1'b0;
                            grant_r  <= '0;
                            ptr_r    <= next_ptr(owner_r);
                        end else begin
                            locked_r <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_WAIT_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_r;
    assign tx_send     = tx_send_r;
    assign tx_data     = tx_data_r;
    assign grant       = grant_r;
    assign locked      = locked_r;
    assign err_timeout = err_timeout_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-cycle comparison against a transaction-level
// reference model, directed scenarios with literal expectations, then randomized traffic.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 15;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            tx_send;
    logic [DW-1:0]   tx_data;
    logic            tx_busy;
    logic [N-1:0]    grant;
    logic            locked;
    logic            err_timeout;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .START_TO(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_send(tx_send),
        .tx_data(tx_data), .tx_busy(tx_busy), .grant(grant), .locked(locked),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // reference model: who owns the transmitter, whether the byte has started, rr pointer
    int           m_ptr, m_owner, m_pick, m_waits;
    bit           m_lock, m_active, m_started, m_last;
    logic [N-1:0] e_ready, e_grant;
    logic         e_send, e_lock, e_err;
    logic [DW-1:0] e_data;

    // environment: requester byte queues {last,data}, transmitter emulation
    logic [8:0]   rq [N][$];
    int           gapc [N];
    int           gap_len [N];
    bit           rand_mode, tx_rand, tx_noresp;
    bit           f_busy, ext_busy;
    int           x_delay, x_len, ext_cnt;
    int           fixed_len;

    // observation log
    logic [DW-1:0] sent_q [$];
    int           ready_cnt [N];
    int           last_send_cyc, last_err_cyc, send_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_owner = -1; m_lock = 0; m_active = 0; m_started = 0;
        m_last = 0; m_waits = 0; m_pick = 0;
        e_ready = '0; e_grant = '0; e_send = 0; e_lock = 0; e_err = 0; e_data = '0;
    endtask

    task automatic release_owner();
        m_ptr    = (m_owner + 1) % N;
        m_owner  = -1;
        m_lock   = 0;
        m_active = 0;
    endtask

    // Advance the model by one rising edge using the inputs the DUT samples at that edge.
    task automatic model_edge();
        int k;
        bit found;
        logic [N-1:0] one;
        one = 1;
        e_ready = '0; e_send = 0; e_err = 0;
        if (rst !== 1'b1) begin
            model_reset();
            return;
        end
        if (!m_active) begin
            if (tx_busy == 1'b0) begin
                found = 0;
                for (int j = 0; j < N; j++) begin
                    k = (m_ptr + j) % N;
                    if (!found && req_valid[k] && (!m_lock || k == m_owner)) begin
                        found      = 1;
                        m_active   = 1;
                        m_owner    = k;
                        m_pick     = cyc;
                        m_started  = 0;
                        m_waits    = 0;
                        m_last     = req_last[k];
                        e_data     = req_data[k*DW +: DW];
                        e_ready[k] = 1'b1;
                        e_send     = 1'b1;
                    end
                end
            end
        end else if (cyc == m_pick + 1) begin
            m_waits = 0;
        end else if (!m_started) begin
            if (tx_busy) begin
                m_started = 1;
            end else begin
                m_waits++;
                if (m_waits == TO) begin
                    e_err = 1'b1;
                    release_owner();
                end
            end
        end else if (!tx_busy) begin
            m_active = 0;
            if (m_last) release_owner();
            else m_lock = 1;
        end
        e_grant = (m_owner >= 0) ? (one << m_owner) : '0;
        e_lock  = m_lock;
    endtask

    task automatic compare_all();
        chk("req_ready", req_ready, e_ready);
        chk("tx_send", tx_send, e_send);
        chk("tx_data", tx_data, e_data);
        chk("grant", grant, e_grant);
        chk("locked", locked, e_lock);
        chk("err_timeout", err_timeout, e_err);
        if (tx_send === 1'b1) begin
            sent_q.push_back(tx_data);
            last_send_cyc = cyc;
            send_count++;
        end
        for (int i = 0; i < N; i++) if (req_ready[i] === 1'b1) ready_cnt[i]++;
        if (err_timeout === 1'b1) last_err_cyc = cyc;
    endtask

    task automatic env_update();
        int len;
        logic [8:0] f;
        logic lb;
        // transmitter: optional start delay, then busy for x_len cycles
        if (f_busy) begin
            if (x_len > 0) x_len--;
            if (x_len == 0) f_busy = 0;
        end else if (x_delay == 0) begin
            f_busy  = 1;
            x_delay = -1;
        end else if (x_delay > 0) begin
            x_delay--;
        end
        if (e_send) begin
            if (tx_noresp || (rand_mode && $urandom_range(0, 9) == 0)) begin
                x_delay = -1;
            end else begin
                x_delay = tx_rand ? int'($urandom_range(0, 3)) : 1;
                x_len   = tx_rand ? int'($urandom_range(1, 6)) : fixed_len;
            end
        end
        if (rand_mode) begin
            if (ext_cnt > 0) ext_cnt--;
            else if ($urandom_range(0, 29) == 0) ext_cnt = $urandom_range(1, 4);
            ext_busy = (ext_cnt > 0);
        end
        tx_busy = f_busy | ext_busy;
        // requesters: present current front byte, retire it after its ready pulse
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0 && gapc[i] == 0) begin
                f = rq[i][0];
                req_valid[i]         = 1'b1;
                req_data[i*DW +: DW] = f[7:0];
                req_last[i]          = f[8];
            end else begin
                req_valid[i] = 1'b0;
            end
            if (e_ready[i]) begin
                if (rq[i].size() > 0) void'(rq[i].pop_front());
                gapc[i] = rand_mode ? int'($urandom_range(0, 2)) : gap_len[i];
            end else if (gapc[i] > 0) begin
                gapc[i]--;
            end
        end
        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                if (rq[i].size() == 0 && $urandom_range(0, 15) == 0) begin
                    len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++) begin
                        lb = (b == len - 1);
                        rq[i].push_back({lb, 8'($urandom)});
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        compare_all();
        env_update();
    endtask

    task automatic wait_send(input int lim);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (tx_send !== 1'b1 && k < lim);
        if (tx_send !== 1'b1) chk("wait_send_bound", tx_send, 1);
    endtask

    task automatic wait_quiet(input int lim);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while ((m_active || f_busy || x_delay >= 0) && k < lim);
        if (k >= lim) chk("wait_quiet_bound", {31'b0, m_active}, 0);
    endtask

    task automatic clear_log();
        sent_q.delete();
        for (int i = 0; i < N; i++) ready_cnt[i] = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout cycle=%0d", cyc);
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [7:0] exp_rr [5];
        int sends;
        rst = 1'b0; req_valid = '0; req_data = '0; req_last = '0; tx_busy = 1'b0;
        rand_mode = 0; tx_rand = 0; tx_noresp = 0; f_busy = 0; ext_busy = 0;
        x_delay = -1; x_len = 0; ext_cnt = 0; fixed_len = 3;
        last_send_cyc = 0; last_err_cyc = 0; send_count = 0;
        for (int i = 0; i < N; i++) begin gapc[i] = 0; gap_len[i] = 0; ready_cnt[i] = 0; end
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_req_ready", req_ready, 4'b0000);
        chk("reset_tx_send", tx_send, 1'b0);
        chk("reset_tx_data", tx_data, 8'h00);
        chk("reset_grant", grant, 4'b0000);
        chk("reset_locked", locked, 1'b0);
        chk("reset_err", err_timeout, 1'b0);
        rst = 1'b1;

        // single byte from requester 2
        rq[2].push_back({1'b1, 8'h61});
        wait_send(20);
        chk("single_ready", req_ready, 4'b0100);
        chk("single_send", tx_send, 1'b1);
        chk("single_data", tx_data, 8'h61);
        chk("single_grant", grant, 4'b0100);
        wait_quiet(50);
        chk("single_grant_after", grant, 4'b0000);
        rq[0].push_back({1'b1, 8'hA0});
        rq[3].push_back({1'b1, 8'hA3});
        wait_send(20);
        chk("after_req2_pick_req3", tx_data, 8'hA3);
        wait_quiet(50);
        wait_send(20);
        chk("then_req0", tx_data, 8'hA0);
        wait_quiet(50);

        // reset in the middle of a frame
        rq[1].push_back({1'b1, 8'hB1});
        wait_send(20);
        chk("pre_reset_b1", tx_data, 8'hB1);
        wait_quiet(50);
        fixed_len = 8;
        rq[2].push_back({1'b1, 8'hB2});
        wait_send(20);
        repeat (4) step();
        chk("midframe_grant", grant, 4'b0100);
        #2;
        rst = 1'b0;
        model_reset();
        f_busy = 0; x_delay = -1; x_len = 0; tx_busy = 1'b0;
        #1;
        chk("async_rst_ready", req_ready, 4'b0000);
        chk("async_rst_send", tx_send, 1'b0);
        chk("async_rst_data", tx_data, 8'h00);
        chk("async_rst_grant", grant, 4'b0000);
        chk("async_rst_locked", locked, 1'b0);
        chk("async_rst_err", err_timeout, 1'b0);
        repeat (2) step();
        rst = 1'b1;
        fixed_len = 3;
        rq[3].push_back({1'b1, 8'hC3});
        rq[0].push_back({1'b1, 8'hC0});
        wait_send(20);
        chk("post_reset_pick_req0", tx_data, 8'hC0);
        chk("post_reset_ready", req_ready, 4'b0001);
        wait_quiet(50);
        wait_send(20);
        wait_quiet(50);

        // round robin over four single-byte messages, requester 0 has a second one
        clear_log();
        exp_rr = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h41};
        rq[0].push_back({1'b1, 8'h41});
        rq[0].push_back({1'b1, 8'h41});
        rq[1].push_back({1'b1, 8'h42});
        rq[2].push_back({1'b1, 8'h43});
        rq[3].push_back({1'b1, 8'h44});
        for (int k = 0; k < 400 && sent_q.size() < 5; k++) step();
        wait_quiet(50);
        chk("rr_count", sent_q.size(), 5);
        for (int i = 0; i < 5 && i < sent_q.size(); i++) chk("rr_order", sent_q[i], exp_rr[i]);
        chk("rr_ready0", ready_cnt[0], 2);
        chk("rr_ready1", ready_cnt[1], 1);
        chk("rr_ready2", ready_cnt[2], 1);
        chk("rr_ready3", ready_cnt[3], 1);

        // locked two-byte message from requester 1; owner pauses valid between bytes
        gap_len[1] = 3;
        rq[1].push_back({1'b0, 8'h68});
        rq[1].push_back({1'b1, 8'h69});
        rq[0].push_back({1'b1, 8'h70});
        rq[2].push_back({1'b1, 8'h72});
        wait_send(20);
        chk("lock_first", tx_data, 8'h68);
        chk("lock_first_unlocked", locked, 1'b0);
        wait_send(40);
        chk("lock_second", tx_data, 8'h69);
        chk("lock_second_locked", locked, 1'b1);
        chk("lock_second_grant", grant, 4'b0010);
        wait_send(40);
        chk("lock_then_req2", tx_data, 8'h72);
        chk("lock_released", locked, 1'b0);
        wait_send(40);
        chk("lock_then_req0", tx_data, 8'h70);
        wait_quiet(50);
        gap_len[1] = 0;

        // start timeout on the second byte of a locked message
        rq[3].push_back({1'b0, 8'h54});
        rq[3].push_back({1'b0, 8'h55});
        wait_send(20);
        chk("to_first", tx_data, 8'h54);
        tx_noresp = 1;
        wait_send(40);
        chk("to_second", tx_data, 8'h55);
        chk("to_locked_before", locked, 1'b1);
        for (int k = 0; k < 40 && err_timeout !== 1'b1; k++) step();
        chk("to_pulse", err_timeout, 1'b1);
        // WAIT_START begins one cycle after tx_send; the pulse comes START_TO cycles after that
        chk("to_delay", cyc - last_send_cyc, TO + 1);
        chk("to_grant", grant, 4'b0000);
        chk("to_locked", locked, 1'b0);
        tx_noresp = 0;
        rq[0].push_back({1'b1, 8'h56});
        rq[3].push_back({1'b1, 8'h57});
        wait_send(20);
        chk("to_next_req0", tx_data, 8'h56);
        wait_quiet(50);
        wait_send(20);
        chk("to_next_req3", tx_data, 8'h57);
        wait_quiet(50);

        // transmitter busy on entry gates selection
        ext_busy = 1;
        sends = send_count;
        rq[0].push_back({1'b1, 8'h66});
        repeat (10) step();
        chk("busy_gate_no_send", send_count - sends, 0);
        ext_busy = 0;
        wait_send(10);
        chk("busy_gate_release", tx_data, 8'h66);
        wait_quiet(50);

        // randomized traffic
        rand_mode = 1;
        tx_rand   = 1;
        repeat (3000) step();
        rand_mode = 0;
        ext_cnt   = 0;
        ext_busy  = 0;
        for (int k = 0; k < 2000 &&
             (rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size() > 0 ||
              m_active || f_busy || x_delay >= 0); k++) step();
        repeat (5) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
